// File: rtl/axi_write_burst_master_if.sv
// rtl/axi_write_burst_master_if.sv - AXI4 write-channel bundle (AW/W/B) for the burst master
//
// Ports (signals):
//   AW: awaddr, awlen, awsize, awburst, awvalid (master->slave), awready (slave->master)
//   W : wdata, wstrb, wlast, wvalid (master->slave), wready (slave->master)
//   B : bresp, bvalid (slave->master), bready (master->slave)
interface axi_write_burst_master_if #(
   parameter int ADDR_WSIZE = 32,
   parameter int DSIZE      = 64
);
   logic [ADDR_WSIZE-1:0] awaddr;
   logic [7:0]            awlen;
   logic [2:0]            awsize;
   logic [1:0]            awburst;
   logic                  awvalid;
   logic                  awready;
   logic [DSIZE-1:0]      wdata;
   logic [DSIZE/8-1:0]    wstrb;
   logic                  wlast;
   logic                  wvalid;
   logic                  wready;
   logic [1:0]            bresp;
   logic                  bvalid;
   logic                  bready;

   modport master (
      output awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bresp, bvalid,
      output bready
   );

   modport slave (
      input  awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bresp, bvalid,
      input  bready
   );
endinterface

// File: rtl/axi_write_burst_master.sv
// rtl/axi_write_burst_master.sv - AXI4 INCR write burst engine for the VDMA write path
//
// Accepts full-burst / tail requests, writes one INCR burst per request with
// data popped from a first-word-fall-through line FIFO, and tracks the frame
// write address (reloaded from base_addr on fsync).
//
// Ports:
//   clock, rst_n            clock, asynchronous active-low reset
//   enable                  allows acceptance of new requests
//   fsync, base_addr        frame start; base byte address sampled on fsync
//   burst_req, tail_req     request FULL_LEN beats / req_len beats
//   req_len                 tail beat count
//   resp, done              request accepted / burst retired (one-cycle pulses)
//   fifo_rd_en, fifo_rd_data  FIFO pop strobe and head word
//   wr_err                  sticky non-OKAY bresp seen this frame
//   axi                     AXI4 write channels (master modport)
module axi_write_burst_master #(
   parameter int ADDR_WSIZE = 32,
   parameter int DSIZE      = 64,
   parameter int LSIZE      = 9,
   parameter int FULL_LEN   = 256
) (
   input  logic                  clock,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  fsync,
   input  logic [ADDR_WSIZE-1:0] base_addr,
   input  logic                  burst_req,
   input  logic                  tail_req,
   input  logic [LSIZE-1:0]      req_len,
   output logic                  resp,
   output logic                  done,
   output logic                  fifo_rd_en,
   input  logic [DSIZE-1:0]      fifo_rd_data,
   output logic                  wr_err,
   axi_write_burst_master_if.master axi
);
   typedef enum logic [1:0] {IDLE, ADDR, DATA, BRESP} state_t;

   localparam int              LW      = LSIZE + 1;
   localparam logic [7:0]      FULL_M1 = 8'(FULL_LEN - 1);
   localparam logic [LW-1:0]   FULL_L  = LW'(FULL_LEN);
   localparam logic [ADDR_WSIZE-1:0] BYTES = ADDR_WSIZE'(DSIZE / 8);

   state_t                state_q, state_d;
   logic [7:0]            len_q, len_d;        // beats - 1 of the current burst
   logic [7:0]            cnt_q, cnt_d;        // W beats handshaken so far
   logic [ADDR_WSIZE-1:0] cur_addr_q, cur_addr_d;
   logic                  pend_q, pend_d;      // fsync seen while a burst was in flight
   logic [ADDR_WSIZE-1:0] pend_addr_q, pend_addr_d;
   logic                  resp_q, resp_d;
   logic                  done_q, done_d;
   logic                  zl_q, zl_d;          // zero-length tail accepted last cycle
   logic                  wr_err_q, wr_err_d;

   logic [LW-1:0]         tail_len;
   logic [7:0]            len_tail;
   logic [ADDR_WSIZE-1:0] burst_bytes;
   logic                  reload;
   logic [ADDR_WSIZE-1:0] reload_addr;

   assign tail_len    = ({1'b0, req_len} > FULL_L) ? FULL_L : {1'b0, req_len};
   assign len_tail    = 8'(tail_len - LW'(1));
   assign burst_bytes = ADDR_WSIZE'({1'b0, len_q} + 9'd1) * BYTES;
   // An fsync arriving in the retiring cycle itself counts as pending.
   assign reload      = fsync || pend_q;
   assign reload_addr = fsync ? base_addr : pend_addr_q;

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      cur_addr_d  = cur_addr_q;
      pend_d      = pend_q;
      pend_addr_d = pend_addr_q;
      resp_d      = 1'b0;
      done_d      = zl_q;
      zl_d        = 1'b0;
      wr_err_d    = wr_err_q;

      if (fsync && state_q != IDLE) begin
         pend_d      = 1'b1;
         pend_addr_d = base_addr;
      end

      case (state_q)
         IDLE: begin
            // Reload lands in cur_addr_q before ADDR drives awaddr from it.
            if (fsync) begin
               cur_addr_d = base_addr;
               wr_err_d   = 1'b0;
            end
            // zl_q marks the resp cycle of a zero-length tail; the request
            // may still be high then and must not be taken twice.
            if (enable && !zl_q && (burst_req || tail_req)) begin
               resp_d = 1'b1;
               if (burst_req) begin
                  len_d   = FULL_M1;
                  state_d = ADDR;
               end else if (req_len == '0) begin
                  zl_d = 1'b1;
               end else begin
                  len_d   = len_tail;
                  state_d = ADDR;
               end
            end
         end
         ADDR: begin
            if (axi.awready) begin
               cnt_d   = 8'd0;
               state_d = DATA;
            end
         end
         DATA: begin
            if (axi.wready) begin
               cnt_d = cnt_q + 8'd1;
               if (cnt_q == len_q) state_d = BRESP;
            end
         end
         BRESP: begin
            if (axi.bvalid) begin
               done_d  = 1'b1;
               state_d = IDLE;
               pend_d  = 1'b0;
               // A pending frame start replaces the incremented address and
               // opens a fresh error window.
               if (reload) begin
                  cur_addr_d = reload_addr;
                  wr_err_d   = 1'b0;
               end else begin
                  cur_addr_d = cur_addr_q + burst_bytes;
                  if (axi.bresp != 2'b00) wr_err_d = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         len_q       <= 8'd0;
         cnt_q       <= 8'd0;
         cur_addr_q  <= '0;
         pend_q      <= 1'b0;
         pend_addr_q <= '0;
         resp_q      <= 1'b0;
         done_q      <= 1'b0;
         zl_q        <= 1'b0;
         wr_err_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         cur_addr_q  <= cur_addr_d;
         pend_q      <= pend_d;
         pend_addr_q <= pend_addr_d;
         resp_q      <= resp_d;
         done_q      <= done_d;
         zl_q        <= zl_d;
         wr_err_q    <= wr_err_d;
      end
   end

   assign resp        = resp_q;
   assign done        = done_q;
   assign wr_err      = wr_err_q;

   assign axi.awvalid = (state_q == ADDR);
   assign axi.awaddr  = cur_addr_q;
   assign axi.awlen   = len_q;
   assign axi.awsize  = 3'($clog2(DSIZE / 8));
   assign axi.awburst = 2'b01;
   assign axi.wvalid  = (state_q == DATA);
   assign axi.wlast   = axi.wvalid && (cnt_q == len_q);
   assign axi.wdata   = fifo_rd_data;
   assign axi.wstrb   = axi.wvalid ? '1 : '0;
   assign axi.bready  = (state_q == BRESP);
   assign fifo_rd_en  = axi.wvalid && axi.wready;
endmodule

// File: doc/axi_write_burst_master.md
# axi_write_burst_master

Write-side AXI4 burst engine for the VDMA write path. Consumes the burst/tail requests raised by the write FIFO status controller, issues one AXI4 INCR write burst per request with data popped from the line FIFO, and returns the `resp` (request accepted) and `done` (burst retired) pulses that controller waits on. Maintains the frame write address, reloaded from `base_addr` at each `fsync`.

## Interface
- `ADDR_WSIZE`, 32, AXI address width
- `DSIZE`, 64, data width in bits; power of two, 8..1024
- `LSIZE`, 9, width of `req_len`
- `FULL_LEN`, 256, beats per full burst; 1..256

- `clock`  in  1  single clock domain
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  allows new requests to be accepted
- `fsync`  in  1  frame start pulse; reloads write address
- `base_addr`  in  ADDR_WSIZE  frame base byte address, sampled on `fsync`
- `burst_req`  in  1  full-burst request (FULL_LEN beats)
- `tail_req`  in  1  tail request (`req_len` beats)
- `req_len`  in  LSIZE  tail beat count
- `resp`  out  1  one-cycle pulse: request accepted
- `done`  out  1  one-cycle pulse: burst write response received
- `fifo_rd_en`  out  1  pop strobe, first-word-fall-through FIFO
- `fifo_rd_data`  in  DSIZE  FIFO head word
- `awaddr` out ADDR_WSIZE; `awlen` out 8; `awsize` out 3; `awburst` out 2; `awvalid` out 1; `awready` in 1
- `wdata` out DSIZE; `wstrb` out DSIZE/8; `wlast` out 1; `wvalid` out 1; `wready` in 1
- `bresp` in 2; `bvalid` in 1; `bready` out 1
- `wr_err`  out  1  sticky: non-OKAY `bresp` seen this frame

## Operation
- FSM states IDLE, ADDR, DATA, BRESP.
- IDLE: if `enable` and (`burst_req` or `tail_req`): latch beats (FULL_LEN for burst, else `req_len`), go ADDR. `burst_req` wins if both high. `tail_req` with `req_len`==0: no AXI traffic; `resp` pulses, `done` pulses the following cycle, stay IDLE. `req_len` > FULL_LEN is clamped to FULL_LEN.
- ADDR: `awvalid`=1, `awaddr`=cur_addr, `awlen`=beats-1; on `awready` go DATA.
- DATA: `wvalid`=1, `wdata`=`fifo_rd_data`, `wstrb` all ones, `fifo_rd_en`=`wvalid&wready`; beat counter increments per handshake; `wlast`=1 when counter==beats-1; handshake with `wlast` goes BRESP.
- BRESP: `bready`=1; on `bvalid`: cur_addr += beats*DSIZE/8 (wraps modulo 2^ADDR_WSIZE), `done` pulse, `bresp`!=0 sets `wr_err`, go IDLE.
- Constants: `awburst`=2'b01, `awsize`=log2(DSIZE/8).
- `fsync` in IDLE: cur_addr<=`base_addr`, `wr_err`<=0. `fsync` outside IDLE: set pending flag, `base_addr` captured then; applied on entry to IDLE, after that burst's address increment (reload wins). Reload takes effect before any request is accepted in that IDLE cycle.
- `enable` low blocks only acceptance; an in-flight burst completes.
- FIFO is guaranteed non-empty for the requested beats by the upstream controller; no empty check.
- 4 KB boundary avoidance is upstream's responsibility (line stride).

## Timing
- Reset: state IDLE, cur_addr 0, `resp` `done` `awvalid` `wvalid` `wlast` `bready` `fifo_rd_en` `wr_err` all 0, `awaddr` 0, `awlen` 0.
- `resp` is a registered pulse one cycle after the accepting IDLE cycle, coincident with first `awvalid`; requester drops its request on `resp`. Request still high in the `resp` cycle is ignored (FSM not in IDLE).
- `awvalid` held until `awready`; address/len stable while waiting.
- First `wvalid` the cycle after AW handshake; W never precedes AW.
- `done` registered, high the cycle after the B handshake; FSM is IDLE in that same cycle and may accept a new request, so minimum request-to-request spacing is beats+3 cycles with zero-wait slave.
- All AXI outputs registered or direct functions of state/counter; `fifo_rd_en` and `wdata` combinational from `wready`/FIFO head.

## Test plan
- Reset mid-DATA (after 10 of 256 beats) -> all outputs 0 immediately, FSM IDLE, cur_addr 0; next `fsync`+request restarts cleanly.
- `fsync` with `base_addr`=0x1000, `burst_req`, DSIZE=64, FULL_LEN=256, slave always ready -> `awaddr`=0x1000, `awlen`=255, 256 pops, `wlast` on 256th beat only, `done` once; next burst `awaddr`=0x1800.
- `tail_req` `req_len`=37 after one full burst -> `awlen`=36, 37 beats, next address 0x1800+37*8=0x1928.
- `wready` toggling 1/0 each cycle, `awready` delayed 5 cycles -> no lost or duplicated beats, `fifo_rd_en` count equals beats, data order matches FIFO.
- `fsync` (`base_addr`=0x8000) during DATA -> current burst finishes at old address; next `awaddr`=0x8000, `wr_err` cleared.
- `bresp`=2'b10 on one burst -> `wr_err`=1 sticky until next `fsync`; `req_len`=0 tail -> `resp` then `done`, no `awvalid`.
